pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_wait_cnt.sv | 31 +++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encodings, the memory-load result-select code and the wait counter width.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl_wait_cnt.sv
// Memory-wait cycle counter: load to 1, increment while waiting, otherwise
// idle at 0; flags when the count has reached LIMIT.
module pipe_ctrl_wait_cnt
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic inc,
   output logic timeout
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(1);
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= '0;
      end
   end

   assign timeout = (count >= CNT_W'(LIMIT));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory freeze FSM with timeout fault,
// branch flush and load-use/CSR stalls. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 256
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_rs1_d,
   input  logic [4:0] i_rs2_d,
   input  logic       i_csr_op_d,
   input  logic [4:0] i_rd_e,
   input  logic [1:0] i_result_src_e,
   input  logic       i_pc_src_e,
   input  logic       i_csr_reg_write_e,
   input  logic       i_csr_reg_write_m,
   input  logic       i_csr_reg_write_w,
   input  logic       i_mem_req_m,
   input  logic       i_mem_ready_m,
   input  logic       i_fault_clr,
   output logic       o_en_f,
   output logic       o_en_fd,
   output logic       o_en_de,
   output logic       o_en_em,
   output logic       o_en_mw,
   output logic       o_flush_fd,
   output logic       o_flush_de,
   output logic       o_mem_fault,
   output logic [1:0] o_state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_cnt
`endif
);

   state_t state;
   logic   freeze_req;
   logic   load_use;
   logic   csr_stall;
   logic   cnt_load;
   logic   cnt_inc;
   logic   timeout;

   assign freeze_req = i_mem_req_m & ~i_mem_ready_m;
   assign load_use   = (i_result_src_e == RESULT_SRC_MEM) && (i_rd_e != 5'd0) &&
                       ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
   assign csr_stall  = i_csr_op_d &
                       (i_csr_reg_write_e | i_csr_reg_write_m | i_csr_reg_write_w);

   // A ready release out of MEM_WAIT resolves hazards exactly as RUN does,
   // since the frozen stage contents still describe the same hazard.
   always_comb begin
      o_en_f     = 1'b0;
      o_en_fd    = 1'b0;
      o_en_de    = 1'b0;
      o_en_em    = 1'b0;
      o_en_mw    = 1'b0;
      o_flush_fd = 1'b0;
      o_flush_de = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      if ((state == ST_RUN && !freeze_req) || (state == ST_MEM_WAIT && i_mem_ready_m)) begin
         o_en_f  = 1'b1;
         o_en_fd = 1'b1;
         o_en_de = 1'b1;
         o_en_em = 1'b1;
         o_en_mw = 1'b1;
         if (i_pc_src_e) begin
            o_flush_fd = 1'b1;
            o_flush_de = 1'b1;
         end else if (load_use || csr_stall) begin
            o_en_f     = 1'b0;
            o_en_fd    = 1'b0;
            o_flush_de = 1'b1;
         end
      end else if (state == ST_FAULT) begin
         o_flush_fd = i_fault_clr;
         o_flush_de = i_fault_clr;
      end
      cnt_load = (state == ST_RUN) && freeze_req;
      cnt_inc  = (state == ST_MEM_WAIT) && !i_mem_ready_m && !timeout;
   end

   pipe_ctrl_wait_cnt #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_cnt (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (cnt_load),
      .inc     (cnt_inc),
      .timeout (timeout)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:      if (freeze_req) state <= ST_MEM_WAIT;
            ST_MEM_WAIT: begin
               if (i_mem_ready_m)  state <= ST_RUN;
               else if (timeout)   state <= ST_FAULT;
            end
            ST_FAULT:    if (i_fault_clr) state <= ST_RUN;
            default:     state <= ST_RUN;
         endcase
      end
   end

   assign o_state     = state;
   assign o_mem_fault = (state == ST_FAULT);

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (!o_en_fd)   o_stall_cnt <= o_stall_cnt + 32'd1;
         if (o_flush_fd) o_flush_cnt <= o_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random stimulus,
// checked against a cycle-level reference model of the control rules.
module tb_pipe_ctrl;

   localparam int unsigned TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
   logic [1:0] result_src_e = '0;
   logic       csr_op_d = 1'b0, pc_src_e = 1'b0;
   logic       csr_we = 1'b0, csr_wm = 1'b0, csr_ww = 1'b0;
   logic       mem_req = 1'b0, mem_ready = 1'b0, fault_clr = 1'b0;
   logic       en_f, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, mem_fault;
   logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_csr_op_d(csr_op_d),
      .i_rd_e(rd_e), .i_result_src_e(result_src_e), .i_pc_src_e(pc_src_e),
      .i_csr_reg_write_e(csr_we), .i_csr_reg_write_m(csr_wm), .i_csr_reg_write_w(csr_ww),
      .i_mem_req_m(mem_req), .i_mem_ready_m(mem_ready), .i_fault_clr(fault_clr),
      .o_en_f(en_f), .o_en_fd(en_fd), .o_en_de(en_de), .o_en_em(en_em), .o_en_mw(en_mw),
      .o_flush_fd(flush_fd), .o_flush_de(flush_de), .o_mem_fault(mem_fault),
      .o_state(state)
`ifdef PIPE_CTRL_PERF_EN
      , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
   );

   typedef struct packed {
      logic       rst;
      logic       req, rdy, clr;
      logic [4:0] rs1, rs2, rd;
      logic [1:0] rsrc;
      logic       pc, csr, we, wm, ww;
   } stim_t;

   typedef struct packed {
      logic [4:0]  en;      // {f, fd, de, em, mw}
      logic        fl_fd, fl_de, fault;
      logic [1:0]  st;
      logic [31:0] stall_c, flush_c;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 = running, 1 = waiting on memory, 2 = faulted.
   int          m_mode = 0;
   int          m_waited = 0;
   logic [31:0] m_stall = '0, m_flush = '0;

   task automatic step(input stim_t s);
      exp_t e;
      bit   hazard, frozen;
      @(posedge clk);
      #1;
      rst_n = s.rst; mem_req = s.req; mem_ready = s.rdy; fault_clr = s.clr;
      rs1_d = s.rs1; rs2_d = s.rs2; rd_e = s.rd; result_src_e = s.rsrc;
      pc_src_e = s.pc; csr_op_d = s.csr; csr_we = s.we; csr_wm = s.wm; csr_ww = s.ww;
      if (!s.rst) begin
         m_mode = 0; m_waited = 0; m_stall = '0; m_flush = '0;
      end
      e = '0;
      e.st = 2'(m_mode);
      e.fault = (m_mode == 2);
      e.stall_c = m_stall;
      e.flush_c = m_flush;
      hazard = (s.rsrc == 2'b01 && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2)) ||
               (s.csr && (s.we || s.wm || s.ww));
      frozen = (m_mode == 0 && s.req && !s.rdy) || (m_mode == 1 && !s.rdy);
      if (m_mode == 2) begin
         e.fl_fd = s.clr;
         e.fl_de = s.clr;
      end else if (!frozen) begin
         e.en = 5'b11111;
         if (s.pc) begin
            e.fl_fd = 1'b1; e.fl_de = 1'b1;
         end else if (hazard) begin
            e.en = 5'b00111; e.fl_de = 1'b1;
         end
      end
      sb.push_back(e);
      if (s.rst) begin
         if (!e.en[3]) m_stall++;
         if (e.fl_fd)  m_flush++;
         if (m_mode == 2) begin
            if (s.clr) m_mode = 0;
         end else if (m_mode == 0) begin
            if (frozen) begin m_mode = 1; m_waited = 1; end
         end else if (s.rdy) begin
            m_mode = 0; m_waited = 0;
         end else if (m_waited >= int'(TMO)) begin
            m_mode = 2; m_waited = 0;
         end else begin
            m_waited++;
         end
      end
   endtask

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("enables", 32'({en_f, en_fd, en_de, en_em, en_mw}), 32'(e.en));
            chk("flush_fd", 32'(flush_fd), 32'(e.fl_fd));
            chk("flush_de", 32'(flush_de), 32'(e.fl_de));
            chk("mem_fault", 32'(mem_fault), 32'(e.fault));
            chk("state", 32'(state), 32'(e.st));
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cnt", stall_cnt, e.stall_c);
            chk("flush_cnt", flush_cnt, e.flush_c);
`endif
         end
      end
   end

   initial begin : driver
      stim_t s, idle;
      idle = '0;
      idle.rst = 1'b1;
      s = '0;
      step(s); step(s);
      repeat (2) step(idle);
      // load-use, then with branch, then rd=0 and CSR serialize
      s = idle; s.rd = 5'd5; s.rsrc = 2'b01; s.rs1 = 5'd5; step(s);
      s.pc = 1'b1; step(s);
      s = idle; s.rsrc = 2'b01; step(s);
      s = idle; s.csr = 1'b1; s.ww = 1'b1; step(s);
      // memory stall released after 3 cycles
      s = idle; s.req = 1'b1;
      repeat (3) step(s);
      s.rdy = 1'b1; step(s);
      // timeout into fault, then clear
      s = idle; s.req = 1'b1;
      repeat (7) step(s);
      s = idle; repeat (2) step(s);
      s.clr = 1'b1; step(s);
      s.clr = 1'b0; step(s);
      // reset during a memory wait
      s = idle; s.req = 1'b1;
      repeat (2) step(s);
      s.rst = 1'b0; step(s);
      s = idle; repeat (2) step(s);
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         s.rst  = ($urandom_range(0, 199) != 0);
         s.req  = ($urandom_range(0, 3) == 0);
         s.rdy  = ($urandom_range(0, 4) == 0);
         s.clr  = ($urandom_range(0, 3) == 0);
         s.rs1  = 5'($urandom_range(0, 7));
         s.rs2  = 5'($urandom_range(0, 7));
         s.rd   = 5'($urandom_range(0, 7));
         s.rsrc = 2'($urandom_range(0, 3));
         s.pc   = ($urandom_range(0, 7) == 0);
         s.csr  = ($urandom_range(0, 3) == 0);
         s.we   = ($urandom_range(0, 5) == 0);
         s.wm   = ($urandom_range(0, 5) == 0);
         s.ww   = ($urandom_range(0, 5) == 0);
         step(s);
      end
      @(posedge clk);
      @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
